// File: rtl/multicycle_cpu_core.sv
// multicycle_cpu_core: one-instruction-at-a-time sequencer
// FETCH -> DECODE -> EXECUTE -> [MEM] -> WRITEBACK, with an internal register file.
// Memory is reached through a registered req/ready handshake, so RAM latency can vary.
module multicycle_cpu_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int NREGS  = 16
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              retired,
    output logic              illegal,
    output logic              halted
);

    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int SH_W  = $clog2(DATA_W);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_MUL  = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_ST   = 4'hB;
    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_RSV  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALTED
    } state_t;

    state_t state, state_nxt;

    logic [31:0]       instr;
    logic [DATA_W-1:0] op_a, op_b, result;
    logic [ADDR_W-1:0] npc;
    logic [DATA_W-1:0] regs [NREGS];

    // Instruction fields
    logic [3:0]        op;
    logic [IDX_W-1:0]  rd_idx, rs1_idx, rs2_idx;
    logic [15:0]       imm;
    logic [DATA_W-1:0] simm;

    assign op      = instr[31:28];
    assign rd_idx  = instr[24 +: IDX_W];
    assign rs1_idx = instr[20 +: IDX_W];
    assign rs2_idx = instr[16 +: IDX_W];
    assign imm     = instr[15:0];
    assign simm    = {{(DATA_W-16){imm[15]}}, imm};

    logic xfer;
    assign xfer = mem_req & mem_ready;

    logic is_mem_op, writes_rd;
    assign is_mem_op = (op == OP_LD) || (op == OP_ST);
    assign writes_rd = (op <= OP_LD);

    // Register 0 always reads as zero regardless of array contents
    logic [DATA_W-1:0] rf_rs1, rf_rs2;
    assign rf_rs1 = (rs1_idx == '0) ? '0 : regs[rs1_idx];
    assign rf_rs2 = (rs2_idx == '0) ? '0 : regs[rs2_idx];

    // ALU result for register-writing ops (LD result comes from memory instead)
    logic [DATA_W-1:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOT:  alu_res = ~op_a;
            OP_SHL:  alu_res = op_a << op_b[SH_W-1:0];
            OP_SHR:  alu_res = op_a >> op_b[SH_W-1:0];
            OP_ADDI: alu_res = op_a + simm;
            OP_MUL:  alu_res = op_a * op_b;
            default: alu_res = '0;
        endcase
    end

    // Effective address and next-PC selection, all modulo 2**ADDR_W
    logic [DATA_W-1:0] eff_sum;
    logic [ADDR_W-1:0] eff_addr, pc_seq, br_tgt, npc_calc;
    assign eff_sum  = op_a + simm;
    assign eff_addr = eff_sum[ADDR_W-1:0];
    assign pc_seq   = pc + ADDR_W'(1);
    assign br_tgt   = pc_seq + simm[ADDR_W-1:0];

    // Branch resolves in EXECUTE so WRITEBACK only has to copy npc
    always_comb begin
        npc_calc = pc_seq;
        case (op)
            OP_BEQ:  npc_calc = (op_a == op_b) ? br_tgt : pc_seq;
            OP_JMP:  npc_calc = imm[ADDR_W-1:0];
            default: npc_calc = pc_seq;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        retired   = 1'b0;
        illegal   = 1'b0;
        halted    = 1'b0;
        case (state)
            S_FETCH:     if (xfer) state_nxt = S_DECODE;
            S_DECODE:    state_nxt = S_EXECUTE;
            S_EXECUTE: begin
                if (is_mem_op)          state_nxt = S_MEM;
                else if (op == OP_HALT) state_nxt = S_HALTED;
                else                    state_nxt = S_WRITEBACK;
            end
            S_MEM:       if (xfer) state_nxt = S_WRITEBACK;
            S_WRITEBACK: begin
                retired   = 1'b1;
                illegal   = (op == OP_RSV);
                state_nxt = S_FETCH;
            end
            S_HALTED:    halted = 1'b1;
            default:     state_nxt = S_FETCH;
        endcase
    end

    // Memory request port: launched one state early so the request is registered,
    // held untouched until accepted, then dropped for at least one cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (xfer) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
            case (state)
                // only reached with req low straight out of reset
                S_FETCH: if (!mem_req) begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                end
                S_EXECUTE: if (is_mem_op) begin
                    mem_req   <= 1'b1;
                    mem_we    <= (op == OP_ST);
                    mem_addr  <= eff_addr;
                    mem_wdata <= op_b;
                end
                S_WRITEBACK: begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= npc;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers: instruction, operands, result, PC
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr  <= '0;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
            npc    <= '0;
            pc     <= '0;
        end else begin
            case (state)
                S_FETCH:     if (xfer) instr <= mem_rdata[31:0];
                S_DECODE: begin
                    op_a <= rf_rs1;
                    op_b <= rf_rs2;
                end
                S_EXECUTE: begin
                    result <= alu_res;
                    npc    <= npc_calc;
                end
                S_MEM:       if (xfer && !mem_we) result <= mem_rdata;
                S_WRITEBACK: pc <= npc;
                default: ;
            endcase
        end
    end

    // Register file write; index 0 is never written
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (state == S_WRITEBACK && writes_rd && rd_idx != '0) begin
            regs[rd_idx] <= result;
        end
    end

endmodule
